// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell and one carry flop. Results appear only when complete.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_r;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;

  // {carry, sum} of a half-adder cell
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic       b_bit;
  logic [1:0] ha0;
  logic [1:0] ha1;
  logic       s_bit;
  logic       c_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    b_bit   = b_sr[0] ^ sub_r;
    ha0     = half_add(a_sr[0], b_bit);
    ha1     = half_add(ha0[0], carry);
    s_bit   = ha1[0];
    c_nxt   = ha0[1] | ha1[1];
    // New bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    res_nxt = {s_bit, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            sub_r  <= sub;
            carry  <= sub;
            cnt    <= '0;
            res_sr <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          carry  <= c_nxt;
          res_sr <= res_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_nxt;
            cout  <= c_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): expected results are queued
// at issue time and popped by a monitor whenever done is seen.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
        chk("sb_cout", 32'(cout), 32'(e[W]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full operation with cycle-exact busy/done checks; operands are scrambled
  // while busy to show they are not re-sampled.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_q.push_back(model(x, y, s));
    a = x; b = y; sub = s; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      cyc(1);
      chk("busy_shift", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
    end
    cyc(1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    cyc(1);
    chk("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // First start accepted on the first edge with rst low.
    rst = 1'b0;
    op(8'h00, 8'h00, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'h5A, 8'hA5, 1'b0);
    op(8'h10, 8'h01, 1'b1);
    op(8'h00, 8'h01, 1'b1);
    for (int k = 0; k < 6; k++) op(W'($urandom), W'($urandom), 1'($urandom));
    chk("q_empty1", 32'(exp_q.size()), 32'd0);

    // A second start during SHIFT is dropped.
    dc = done_cnt;
    exp_q.push_back(model(8'h03, 8'h04, 1'b0));
    a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    chk("drop_done", 32'(done), 32'd1);
    chk("drop_sum", 32'(sum), 32'h07);
    cyc(15);
    chk("drop_single", 32'(done_cnt - dc), 32'd1);

    // Reset mid-operation aborts silently.
    dc = done_cnt;
    a = 8'h33; b = 8'h44; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    cyc(20);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    op(8'h01, 8'h01, 1'b0);
    chk("post_abort_sum", 32'(sum), 32'h02);

    // start held high: back-to-back operations every W+2 cycles.
    dc = done_cnt;
    repeat (3) exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    cyc(1);
    for (int i = 1; i < 3 * (W + 2); i++) begin
      cyc(1);
      chk("hold_done", 32'(done), 32'((i % (W + 2)) == W));
      chk("hold_busy", 32'(busy), 32'((i % (W + 2)) < W));
      if (i >= W) chk("hold_sum", 32'(sum), 32'h03);
    end
    start = 1'b0;
    cyc(W + 4);
    chk("hold_count", 32'(done_cnt - dc), 32'd3);
    chk("q_empty2", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port: sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 The block SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-007 The block SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 The block SHALL have port: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 The block SHALL have port: done  output  1  single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port: sum  output  WIDTH  registered result.
REQ-011 The block SHALL have port: cout  output  1  registered final carry (for sub: 1 = no borrow).

Function
REQ-012 The block SHALL compute one result bit per cycle, LSB first, using a single 1-bit adder stage built from two half-adder cells plus an OR, and one carry flop.
REQ-013 The block SHALL implement three FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE -> SHIFT SHALL occur on an edge sampling start=1; a, b and sub are latched into internal shift registers; the bit counter is cleared; the carry flop loads sub.
REQ-015 In SHIFT, the B bit SHALL be inverted when the latched sub=1.
REQ-016 In SHIFT, each edge SHALL process bit index = counter: result bit = A^B'^c; carry <= majority(A, B', c); operands shift right; counter increments.
REQ-017 SHIFT -> DONE SHALL occur on the edge processing bit WIDTH-1; on that same edge sum takes the full assembled result and cout takes the final carry.
REQ-018 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-019 Latency: done SHALL be high exactly WIDTH cycles after the edge that sampled start, for exactly one cycle.
REQ-020 sum and cout SHALL change only on the SHIFT->DONE edge or on reset; partial results are never visible. Values hold until the next completed operation.
REQ-021 busy SHALL be 1 exactly when the state is SHIFT; done SHALL be 1 exactly when the state is DONE.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored and not queued; a, b and sub changes in those states SHALL have no effect.
REQ-023 start held high continuously SHALL begin a new operation on each IDLE visit, giving back-to-back ops every WIDTH+2 cycles.
REQ-024 Results SHALL be modulo 2^WIDTH; overflow is reported only through cout.

Reset
REQ-025 rst=1 on a rising edge SHALL force state IDLE, counter 0, carry 0, internal registers 0, busy 0, done 0, sum 0, cout 0.
REQ-026 rst SHALL take priority over start and over any FSM transition, including mid-SHIFT; an aborted operation SHALL never produce done.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=8)
REQ-028 a=0x00, b=0x00, sub=0, start pulse -> busy high 8 cycles; done 8 cycles after the start edge; sum=0x00, cout=0.
REQ-029 a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1; a=0x5A, b=0xA5 -> sum=0xFF, cout=0.
REQ-030 sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x00, b=0x01 -> sum=0xFF, cout=0.
REQ-031 start with a=0x03, b=0x04, then a start pulse at cycle 3 with a=0xF0, b=0x0F -> a single done; sum=0x07; second request dropped.
REQ-032 rst asserted for 1 cycle at cycle 4 of an operation -> next cycle busy=0, done=0, sum=0x00, cout=0; no done for 20 cycles; a following start with 0x01+0x01 gives sum=0x02.
REQ-033 start held high with a=0x01, b=0x02 -> done pulses every 10 cycles; sum stable at 0x03 between pulses.
